// File: rtl/seg_reader_if.sv
// rtl/seg_reader_if.sv - segment display sense lines and decoded result port bundle.
interface seg_reader_if;
  logic       a, b, c, d, e, f, g;
  logic       sel;
  logic       out_ready;
  logic       ovf_clr;
  logic [3:0] data;
  logic       blank;
  logic       err;
  logic       out_valid;
  logic       overflow;

  modport master (
    output a, b, c, d, e, f, g, sel, out_ready, ovf_clr,
    input  data, blank, err, out_valid, overflow
  );

  modport slave (
    input  a, b, c, d, e, f, g, sel, out_ready, ovf_clr,
    output data, blank, err, out_valid, overflow
  );
endinterface

// File: rtl/seg_reader.sv
// rtl/seg_reader.sv - debounced seven-segment digit reader with a one-entry result register.
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_reader_if.slave  bus
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [7:0] samp_q, samp_d;
  logic       samp_vld_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic [3:0] data_q, data_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic       accept;
  logic       new_res;
  logic       drop;
  logic [3:0] dec_data;
  logic       dec_blank;
  logic       dec_err;

  // sel=1 blanks the display, so its segment lines are folded away before comparison
  always_comb begin
    samp_d = bus.sel ? 8'h80 : {1'b0, bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (samp_vld_q) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
          cand_d  = samp_q;
        end
      end
      SETTLE: begin
        if (samp_q == cand_q) begin
          if (cnt_q >= STABLE_C - 8'd1) begin
            cnt_d   = STABLE_C;
            accept  = 1'b1;
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d  = 8'd1;
          cand_d = samp_q;
        end
      end
      LOCKED: begin
        if (samp_q != cand_q) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
          cand_d  = samp_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    dec_data  = 4'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    if (cand_q[7] || cand_q[6:0] == 7'b0000000) begin
      dec_blank = 1'b1;
    end else begin
      case (cand_q[6:0])
        7'b1111110: dec_data = 4'd0;
        7'b0110000: dec_data = 4'd1;
        7'b1101101: dec_data = 4'd2;
        7'b1111001: dec_data = 4'd3;
        7'b0110011: dec_data = 4'd4;
        7'b1011011: dec_data = 4'd5;
        7'b1011111: dec_data = 4'd6;
        7'b1110000: dec_data = 4'd7;
        7'b1111111: dec_data = 4'd8;
        7'b1111011: dec_data = 4'd9;
        default:    dec_err  = 1'b1;
      endcase
    end
  end

  // Re-accepting the pattern already reported is not a new result
  always_comb begin
    new_res    = accept && (!last_vld_q || cand_q != last_q);
    drop       = new_res && valid_q && !bus.out_ready;
    last_d     = accept ? cand_q : last_q;
    last_vld_d = last_vld_q | accept;
    data_d     = data_q;
    blank_d    = blank_q;
    err_d      = err_q;
    valid_d    = valid_q;
    if (new_res && !drop) begin
      data_d  = dec_data;
      blank_d = dec_blank;
      err_d   = dec_err;
      valid_d = 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      samp_q     <= 8'd0;
      samp_vld_q <= 1'b0;
      cnt_q      <= 8'd0;
      cand_q     <= 8'd0;
      last_q     <= 8'd0;
      last_vld_q <= 1'b0;
      data_q     <= 4'd0;
      blank_q    <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      samp_vld_q <= 1'b1;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      data_q     <= data_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.blank     = blank_q;
  assign bus.err       = err_q;
  assign bus.out_valid = valid_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: number of consecutive identical samples required before a segment pattern is accepted.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a,b,c,d,e,f,g  input  1 each  segment lines; 1 = segment lit.
REQ-005 sel  input  1  digit enable, active-low; sel=1 means the display is off.
REQ-006 out_ready  input  1  consumer accepts the held result when high with out_valid.
REQ-007 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-008 data  output  4  decoded BCD digit, 0..9.
REQ-009 blank  output  1  accepted pattern is all-off or sel=1.
REQ-010 err  output  1  accepted pattern is not a legal digit and not blank.
REQ-011 out_valid  output  1  data/blank/err hold a new result.
REQ-012 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-013 Inputs {sel,a..g} SHALL be registered once (sample stage) before any comparison.
REQ-014 The decode table, {a..g} with sel=0, SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-015 The decode SHALL give blank=1, data=0, err=0 for 0000000 or sel=1 (segments ignored).
REQ-016 The decode SHALL give err=1, data=0, blank=0 for any other pattern.
REQ-017 The FSM SHALL have states IDLE, SETTLE and LOCKED.
REQ-018 IDLE (after reset): the first sample moves to SETTLE with the stability count=1.
REQ-019 SETTLE: each equal sample increments the count; a differing sample restarts the count at 1.
REQ-020 SETTLE: at count=STABLE_CYCLES the pattern SHALL be accepted and the FSM moves to LOCKED.
REQ-021 An acceptance SHALL generate a result only if the pattern differs from the last accepted pattern, or if it is the first acceptance after reset.
REQ-022 LOCKED: any sample differing from the locked pattern SHALL return to SETTLE with count=1.
REQ-023 Latency: a pattern stable across STABLE_CYCLES consecutive sample-stage edges SHALL assert out_valid on the following edge, i.e. STABLE_CYCLES+1 edges after it first appears at the inputs.
REQ-024 Output register: one entry; data/blank/err are stable while out_valid=1.
REQ-025 out_valid SHALL clear on the edge where out_valid=1 and out_ready=1, unless a new result loads on that same edge.
REQ-026 A new result arriving with out_valid=1 and out_ready=0 SHALL be dropped, overflow SHALL set, and the held result SHALL be unchanged.
REQ-027 A new result arriving with out_valid=1 and out_ready=1 SHALL load, out_valid SHALL stay 1, and overflow SHALL not set.
REQ-028 ovf_clr=1 SHALL clear overflow on the next edge; if a drop occurs on the same edge, set takes priority.
REQ-029 The stability counter SHALL saturate at STABLE_CYCLES and never wrap.

Reset
REQ-030 rst_n=0 SHALL immediately force data=0, blank=0, err=0, out_valid=0 and overflow=0.
REQ-031 rst_n=0 SHALL immediately force FSM=IDLE, count=0, and clear the sample stage and the last-accepted record.
REQ-032 Reset asserted mid-SETTLE or with out_valid=1 SHALL discard all pending state; after release, behaviour is as from power-up.

Verification (STABLE_CYCLES=4)
REQ-033 After reset, hold sel=0, 1011011 and out_ready=0 -> out_valid=1 after the 5th edge, data=5, blank=0, err=0.
REQ-034 Hold 0110000 for 3 edges, then 1111001 for 4 edges -> one result only, data=3; no result for the digit-1 pattern.
REQ-035 Hold 1111111 until accepted, then hold it 20 more edges with out_ready=1 -> exactly one out_valid pulse, data=8.
REQ-036 Hold 1001001, then sel=1 with any segments -> first result err=1, then blank=1 once the result is consumed.
REQ-037 Keep out_ready=0 and accept digit 2, then digit 7 -> held data stays 2 and overflow=1; ovf_clr=1 -> overflow=0 next edge.
REQ-038 Assert rst_n=0 during SETTLE at count=3, release, then re-present the same pattern -> 5 full edges required, and outputs are 0 during reset.
